param_restoring_divider: RTL and testbench



---
 rtl/div_pkg.sv | 21 ++
 rtl/param_restoring_divider_if.sv | 27 ++
 rtl/div_step.sv | 26 ++
 rtl/param_restoring_divider.sv | 137 +++++++++++++
 tb/tb_param_restoring_divider.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider: FSM states, default sizing,
// and a width-agnostic conditional two's-complement negation.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DIV_WIDTH = 8;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam int unsigned NEG_W     = 64;

  // Callers zero-extend into NEG_W bits and truncate the result back to their width.
  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x, input logic neg);
    return neg ? (NEG_W'(0) - x) : x;
  endfunction

endpackage

// File: rtl/param_restoring_divider_if.sv
// Start/done handshake and result bus between the issue logic and the divider.
interface param_restoring_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, signed_mode, A, B,
    input  quotient, remainder, div_by_zero, overflow, busy, done
  );

  modport slave (
    input  start, signed_mode, A, B,
    output quotient, remainder, div_by_zero, overflow, busy, done
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left, subtract the divisor if it fits.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;

  // r < m keeps the shifted remainder below 2^(WIDTH+1), so one extra bit suffices.
  always_comb begin
    r_sh  = {r, q[WIDTH-1]};
    trial = r_sh - {1'b0, m};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_sh[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/param_restoring_divider.sv
// Multi-cycle signed/unsigned restoring divider, one iteration per clock.
// Optional DIV_EARLY_ZERO_EN: a zero divisor skips the iterations and goes straight to FIX.
module param_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic                     clk,
  input logic                     rst,
  param_restoring_divider_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] r, r_next, q, q_next, m, m_next, a_raw, a_raw_next;
  logic             qsign, qsign_next, rsign, rsign_next;
  logic             dz, dz_next, ovf, ovf_next;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] quotient_next, remainder_next;
  logic             div_by_zero_next, overflow_next, busy_next, done_next;
  logic [WIDTH-1:0] step_r, step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q      (q),
    .m      (m),
    .r_next (step_r),
    .q_next (step_q)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    r_next           = r;
    q_next           = q;
    m_next           = m;
    a_raw_next       = a_raw;
    qsign_next       = qsign;
    rsign_next       = rsign;
    dz_next          = dz;
    ovf_next         = ovf;
    neg_a            = 1'b0;
    neg_b            = 1'b0;
    quotient_next    = bus.quotient;
    remainder_next   = bus.remainder;
    div_by_zero_next = bus.div_by_zero;
    overflow_next    = bus.overflow;

    case (state)
      IDLE: begin
        if (bus.start) begin
          neg_a      = bus.signed_mode & bus.A[WIDTH-1];
          neg_b      = bus.signed_mode & bus.B[WIDTH-1];
          q_next     = WIDTH'(cond_neg(NEG_W'(bus.A), neg_a));
          m_next     = WIDTH'(cond_neg(NEG_W'(bus.B), neg_b));
          r_next     = '0;
          a_raw_next = bus.A;
          qsign_next = neg_a ^ neg_b;
          rsign_next = neg_a;
          dz_next    = (bus.B == '0);
          ovf_next   = bus.signed_mode && (bus.A == MIN_VAL) && (bus.B == '1);
          cnt_next   = CNT_W'(WIDTH - 1);
`ifdef DIV_EARLY_ZERO_EN
          state_next = (bus.B == '0) ? FIX : ITER;
`else
          state_next = ITER;
`endif
        end
      end
      ITER: begin
        r_next   = step_r;
        q_next   = step_q;
        cnt_next = cnt - CNT_W'(1);
        if (cnt == '0) state_next = FIX;
      end
      FIX: begin
        // MIN / -1 already yields MIN through the magnitude path; only the flag is extra.
        if (dz) begin
          quotient_next  = '1;
          remainder_next = a_raw;
        end else begin
          quotient_next  = WIDTH'(cond_neg(NEG_W'(q), qsign));
          remainder_next = WIDTH'(cond_neg(NEG_W'(r), rsign));
        end
        div_by_zero_next = dz;
        overflow_next    = ovf;
        state_next       = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == ITER) || (state_next == FIX);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      r               <= '0;
      q               <= '0;
      m               <= '0;
      a_raw           <= '0;
      qsign           <= 1'b0;
      rsign           <= 1'b0;
      dz              <= 1'b0;
      ovf             <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      r               <= r_next;
      q               <= q_next;
      m               <= m_next;
      a_raw           <= a_raw_next;
      qsign           <= qsign_next;
      rsign           <= rsign_next;
      dz              <= dz_next;
      ovf             <= ovf_next;
      bus.quotient    <= quotient_next;
      bus.remainder   <= remainder_next;
      bus.div_by_zero <= div_by_zero_next;
      bus.overflow    <= overflow_next;
      bus.busy        <= busy_next;
      bus.done        <= done_next;
    end
  end
endmodule

// File: tb/tb_param_restoring_divider.sv
// Randomised and directed bench for param_restoring_divider against an integer-arithmetic model.
module tb_param_restoring_divider;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  param_restoring_divider_if #(.WIDTH(W)) bus ();

  param_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } res_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truncating division via native int arithmetic; remainder sign follows the dividend.
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    res_t x;
    int   sa, sb;
    x = '0;
    if (b == '0) begin
      x.q  = '1;
      x.r  = a;
      x.dz = 1'b1;
    end else if (sm) begin
      sa    = int'($signed(a));
      sb    = int'($signed(b));
      x.q   = W'(sa / sb);
      x.r   = W'(sa % sb);
      x.ovf = (sa == -(1 << (W - 1))) && (sb == -1);
    end else begin
      x.q = a / b;
      x.r = a % b;
    end
    return x;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input bit inject);
    res_t e, got;
    int   lat, exp_lat, extra_done;
    bit   seen, busy_ok;
    e       = ref_div(a, b, sm);
    exp_lat = W + 2;
`ifdef DIV_EARLY_ZERO_EN
    if (b == '0) exp_lat = 2;
`endif
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.signed_mode = sm;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.A = W'($urandom); bus.B = W'($urandom); bus.signed_mode = 1'($urandom);
    lat = 0; busy_ok = 1'b1; got = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      seen = bus.done;
      if (seen) begin
        got = '{bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow};
        if (bus.busy) busy_ok = 1'b0;
      end else if (!bus.busy) busy_ok = 1'b0;
      if (inject && k == 3) begin
        bus.start = 1'b1; bus.A = 8'h11; bus.B = 8'h02; bus.signed_mode = 1'b0;
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      if (seen) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("quotient", 32'(got.q), 32'(e.q));
    check("remainder", 32'(got.r), 32'(e.r));
    check("div_by_zero", 32'(got.dz), 32'(e.dz));
    check("overflow", 32'(got.ovf), 32'(e.ovf));
    check("busy_window", 32'(busy_ok), 32'd1);
    extra_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("single_done", 32'(extra_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_dz", 32'(bus.div_by_zero), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // Directed cases, including the zero-divisor and MIN/-1 corners.
    do_op(8'hF9, 8'h02, 1'b1, 1'b0);
    do_op(8'd200, 8'd3, 1'b0, 1'b0);
    do_op(8'd100, 8'hF9, 1'b1, 1'b0);
    do_op(8'h5A, 8'h00, 1'b0, 1'b0);
    do_op(8'h5A, 8'h00, 1'b1, 1'b0);
    do_op(8'hA5, 8'h00, 1'b1, 1'b0);
    do_op(8'h80, 8'hFF, 1'b1, 1'b0);
    do_op(8'h80, 8'hFF, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0);
    do_op(8'h07, 8'h80, 1'b1, 1'b0);
    do_op(8'd200, 8'd7, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] a, b;
      logic         sm;
      sm = 1'($urandom_range(0, 1));
      a  = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        2:       begin a = 8'h80; b = 8'hFF; end
        default: b = W'($urandom);
      endcase
      do_op(a, b, sm, 1'b0);
    end

    // Abort mid-operation: outputs clear at once and no done follows.
    do_op(8'h80, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'd200; bus.B = 8'd3; bus.signed_mode = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_ovf", 32'(bus.overflow), 32'd0);
    check("abort_dz", 32'(bus.div_by_zero), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    do_op(8'd9, 8'd3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
